// File: rtl/dmem_wbuf_if.sv
// dmem_wbuf_if
// Store/load bus between the execute stage (master) and the data-memory
// responder dmem_wbuf (slave).
//
// Signals:
//   mem_wr_req_i   store request, one store per asserted cycle
//   mem_wr_sel_i   byte-lane enables for the store
//   mem_wr_addr_i  store byte address
//   mem_wr_data_i  lane-aligned store data
//   mem_rd_req_i   load request
//   mem_rd_addr_i  load byte address
//   mem_rd_data_o  merged load data, held until the next load completes
//   mem_rd_valid_o one-cycle pulse, one cycle after a load request
//   hold_flag_o    write buffer full, stall stores
//   overflow_o     sticky, a store was dropped
interface dmem_wbuf_if;
  logic        mem_wr_req_i;
  logic [3:0]  mem_wr_sel_i;
  logic [31:0] mem_wr_addr_i;
  logic [31:0] mem_wr_data_i;
  logic        mem_rd_req_i;
  logic [31:0] mem_rd_addr_i;
  logic [31:0] mem_rd_data_o;
  logic        mem_rd_valid_o;
  logic        hold_flag_o;
  logic        overflow_o;

  modport master (
    output mem_wr_req_i, mem_wr_sel_i, mem_wr_addr_i, mem_wr_data_i,
    output mem_rd_req_i, mem_rd_addr_i,
    input  mem_rd_data_o, mem_rd_valid_o, hold_flag_o, overflow_o
  );

  modport slave (
    input  mem_wr_req_i, mem_wr_sel_i, mem_wr_addr_i, mem_wr_data_i,
    input  mem_rd_req_i, mem_rd_addr_i,
    output mem_rd_data_o, mem_rd_valid_o, hold_flag_o, overflow_o
  );
endinterface

// File: rtl/dmem_wbuf.sv
// dmem_wbuf
// Data-memory responder with a posted write buffer. Stores are queued in a
// small circular FIFO and drained into a single-port synchronous word RAM on
// every cycle without a load. Loads complete in one cycle; their data merges
// the RAM word with any still-buffered stores (and a same-cycle store), so
// program order is preserved.
//
// Parameters:
//   AW        RAM word-address width (depth 2^AW words of 32 bits)
//   WB_DEPTH  write-buffer entries, power of two, >= 2
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   bus       dmem_wbuf_if.slave store/load bus
module dmem_wbuf #(
  parameter int AW       = 12,
  parameter int WB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  dmem_wbuf_if.slave  bus
);

  localparam int PW = $clog2(WB_DEPTH);

  typedef logic [AW-1:0] idx_t;

  // storage
  logic [31:0] ram [2**AW];
  logic [31:0] ram_q;

  idx_t        wb_idx  [WB_DEPTH];
  logic [3:0]  wb_sel  [WB_DEPTH];
  logic [31:0] wb_data [WB_DEPTH];

  logic [PW-1:0] head, tail;
  logic [PW:0]   count, count_next;

  // request decode
  idx_t wr_idx, rd_idx;
  logic enq_req, full, drain, accept, drop;

  // load path
  logic [3:0]  fwd_mask, fwd_mask_q;
  logic [31:0] fwd_data, fwd_data_q;
  logic        rd_valid_q;
  logic [31:0] rd_merged, rd_held;

  logic hold_q, overflow_q;

  assign wr_idx = bus.mem_wr_addr_i[AW+1:2];
  assign rd_idx = bus.mem_rd_addr_i[AW+1:2];

  // Address bits outside the word index are ignored by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.mem_wr_addr_i[31:AW+2], bus.mem_wr_addr_i[1:0],
                              bus.mem_rd_addr_i[31:AW+2], bus.mem_rd_addr_i[1:0]};

  assign enq_req = bus.mem_wr_req_i && (bus.mem_wr_sel_i != 4'b0000);
  assign full    = (count == (PW+1)'(WB_DEPTH));
  // A load owns the RAM port, so draining only happens on load-free cycles.
  assign drain   = (count != '0) && !bus.mem_rd_req_i;
  // When full, a store still fits if the head leaves in the same cycle.
  assign accept  = enq_req && (!full || drain);
  assign drop    = enq_req && !accept;

  always_comb begin
    count_next = count;
    if (accept && !drain)
      count_next = count + 1'b1;
    else if (!accept && drain)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      hold_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (accept)
        tail <= tail + 1'b1;
      if (drain)
        head <= head + 1'b1;
      count  <= count_next;
      hold_q <= (count_next == (PW+1)'(WB_DEPTH));
      if (drop)
        overflow_q <= 1'b1;
    end
  end

  // Entry payloads need no reset; validity comes from head/count.
  always_ff @(posedge clk) begin
    if (accept) begin
      wb_idx[tail]  <= wr_idx;
      wb_sel[tail]  <= bus.mem_wr_sel_i;
      wb_data[tail] <= bus.mem_wr_data_i;
    end
  end

  // Single RAM port: read for a load, otherwise byte-masked write of the head.
  always_ff @(posedge clk) begin
    if (bus.mem_rd_req_i) begin
      ram_q <= ram[rd_idx];
    end else if (drain) begin
      for (int k = 0; k < 4; k++) begin
        if (wb_sel[head][k])
          ram[wb_idx[head]][8*k +: 8] <= wb_data[head][8*k +: 8];
      end
    end
  end

  // Forwarding walks the buffer oldest to newest so later stores overwrite
  // earlier ones per lane; an accepted same-cycle store is the newest source.
  always_comb begin
    fwd_mask = '0;
    fwd_data = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if ((i < int'(count)) && (wb_idx[head + PW'(i)] == rd_idx)) begin
        for (int k = 0; k < 4; k++) begin
          if (wb_sel[head + PW'(i)][k]) begin
            fwd_mask[k]          = 1'b1;
            fwd_data[8*k +: 8]   = wb_data[head + PW'(i)][8*k +: 8];
          end
        end
      end
    end
    if (accept && (wr_idx == rd_idx)) begin
      for (int k = 0; k < 4; k++) begin
        if (bus.mem_wr_sel_i[k]) begin
          fwd_mask[k]        = 1'b1;
          fwd_data[8*k +: 8] = bus.mem_wr_data_i[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      fwd_mask_q <= '0;
      fwd_data_q <= '0;
      rd_held    <= '0;
    end else begin
      rd_valid_q <= bus.mem_rd_req_i;
      if (bus.mem_rd_req_i) begin
        fwd_mask_q <= fwd_mask;
        fwd_data_q <= fwd_data;
      end
      if (rd_valid_q)
        rd_held <= rd_merged;
    end
  end

  always_comb begin
    rd_merged = ram_q;
    for (int k = 0; k < 4; k++) begin
      if (fwd_mask_q[k])
        rd_merged[8*k +: 8] = fwd_data_q[8*k +: 8];
    end
  end

  // The merged word is presented in the valid cycle and then held.
  assign bus.mem_rd_data_o  = rd_valid_q ? rd_merged : rd_held;
  assign bus.mem_rd_valid_o = rd_valid_q;
  assign bus.hold_flag_o    = hold_q;
  assign bus.overflow_o     = overflow_q;

endmodule

// File: tb/tb_dmem_wbuf.sv
// tb_dmem_wbuf
// Self-checking bench for dmem_wbuf (AW=12, WB_DEPTH=4). A behavioural model
// keeps committed memory plus a queue of posted stores; every load pushes its
// expected word into a scoreboard that is popped when the valid pulse shows.
module tb_dmem_wbuf;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  dmem_wbuf_if bus();

  dmem_wbuf #(.AW(12), .WB_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [11:0] idx;
    logic [3:0]  sel;
    logic [31:0] data;
  } store_t;

  store_t      mbuf[$];
  logic [31:0] mram[int];
  logic [31:0] exp_q[$];

  int   n_checks = 0;
  int   n_errors = 0;
  bit   checking_on = 1'b0;
  logic exp_valid = 1'b0;
  logic exp_hold  = 1'b0;
  logic exp_ovf   = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge_bytes(input logic [31:0] w, input logic [3:0] sel,
                                              input logic [31:0] d);
    logic [31:0] r;
    r = w;
    for (int k = 0; k < 4; k++)
      if (sel[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ram_word(input logic [11:0] idx);
    if (mram.exists(int'(idx))) return mram[int'(idx)];
    return 32'hxxxxxxxx;
  endfunction

  // Drives one cycle of stimulus, updates the model, and waits past the edge.
  task automatic applyStimulus(input logic wr, input logic [3:0] sel, input logic [31:0] waddr,
                               input logic [31:0] wdata, input logic rd, input logic [31:0] raddr);
    logic        enq, drain, accept;
    logic [11:0] widx, ridx;
    logic [31:0] word;
    store_t      e;
    bus.mem_wr_req_i  = wr;
    bus.mem_wr_sel_i  = sel;
    bus.mem_wr_addr_i = waddr;
    bus.mem_wr_data_i = wdata;
    bus.mem_rd_req_i  = rd;
    bus.mem_rd_addr_i = raddr;
    widx   = waddr[13:2];
    ridx   = raddr[13:2];
    enq    = wr && (sel != 4'b0000);
    drain  = (mbuf.size() > 0) && !rd;
    accept = enq && ((mbuf.size() < 4) || drain);
    if (rd) begin
      word = ram_word(ridx);
      foreach (mbuf[i])
        if (mbuf[i].idx == ridx) word = merge_bytes(word, mbuf[i].sel, mbuf[i].data);
      if (accept && (widx == ridx)) word = merge_bytes(word, sel, wdata);
      exp_q.push_back(word);
    end
    if (drain) begin
      e = mbuf.pop_front();
      mram[int'(e.idx)] = merge_bytes(ram_word(e.idx), e.sel, e.data);
    end
    if (accept) begin
      e.idx = widx; e.sel = sel; e.data = wdata;
      mbuf.push_back(e);
    end
    @(posedge clk);
    #1;
    exp_valid = rd;
    exp_hold  = (mbuf.size() == 4);
    if (enq && !accept) exp_ovf = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d);
    applyStimulus(1'b1, 4'hF, a, d, 1'b0, 32'h0);
  endtask

  task automatic lw(input logic [31:0] a);
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, a);
  endtask

  // Asynchronous reset from mid-cycle; buffered stores and pending loads vanish.
  task automatic doReset();
    bus.mem_wr_req_i = 1'b0;
    bus.mem_wr_sel_i = 4'h0;
    bus.mem_rd_req_i = 1'b0;
    rst_n = 1'b0;
    mbuf.delete();
    exp_q.delete();
    exp_valid = 1'b0;
    exp_hold  = 1'b0;
    exp_ovf   = 1'b0;
    #1;
    checkOutput("rst_rd_data",  bus.mem_rd_data_o, 32'h0);
    checkOutput("rst_rd_valid", {31'b0, bus.mem_rd_valid_o}, 32'h0);
    checkOutput("rst_hold",     {31'b0, bus.hold_flag_o}, 32'h0);
    checkOutput("rst_overflow", {31'b0, bus.overflow_o}, 32'h0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (checking_on && rst_n) begin
      checkOutput("rd_valid", {31'b0, bus.mem_rd_valid_o}, {31'b0, exp_valid});
      if (bus.mem_rd_valid_o === 1'b1) begin
        if (exp_q.size() > 0)
          checkOutput("rd_data", bus.mem_rd_data_o, exp_q.pop_front());
        else
          checkOutput("rd_unexpected", 32'h1, 32'h0);
      end
      checkOutput("hold_flag", {31'b0, bus.hold_flag_o}, {31'b0, exp_hold});
      checkOutput("overflow",  {31'b0, bus.overflow_o},  {31'b0, exp_ovf});
    end
  end

  initial begin
    bus.mem_wr_req_i  = 1'b0;
    bus.mem_wr_sel_i  = 4'h0;
    bus.mem_wr_addr_i = 32'h0;
    bus.mem_wr_data_i = 32'h0;
    bus.mem_rd_req_i  = 1'b0;
    bus.mem_rd_addr_i = 32'h0;
    #1;
    doReset();
    checking_on = 1'b1;

    // preload words that later loads depend on
    sw(32'h100, 32'h0);
    sw(32'h040, 32'h11223344);
    sw(32'h200, 32'h0);
    sw(32'h500, 32'hA5A5_0500);
    sw(32'h504, 32'hA5A5_0504);
    sw(32'h508, 32'hA5A5_0508);
    sw(32'h604, 32'h0604_0604);
    idle(8);

    // store then load the same word, same cycle and next cycle
    applyStimulus(1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 1'b1, 32'h100);
    lw(32'h100);
    idle(3);

    // byte merge with both stores still buffered, then after drain
    applyStimulus(1'b1, 4'b0010, 32'h41, 32'h0000AA00, 1'b1, 32'h40);
    applyStimulus(1'b1, 4'b1000, 32'h43, 32'hBB000000, 1'b1, 32'h40);
    lw(32'h40);
    checkOutput("merge_buffered", bus.mem_rd_data_o, 32'hBB22AA44);
    idle(4);
    lw(32'h40);
    checkOutput("merge_drained", bus.mem_rd_data_o, 32'hBB22AA44);
    idle(2);

    // newest store wins under continuous loads
    applyStimulus(1'b1, 4'hF, 32'h200, 32'h1, 1'b1, 32'h200);
    applyStimulus(1'b1, 4'hF, 32'h200, 32'h2, 1'b1, 32'h200);
    lw(32'h200);
    lw(32'h200);
    checkOutput("newest_wins", bus.mem_rd_data_o, 32'h2);
    idle(4);

    // fill buffer under loads, drop under a load, accept on a drain cycle
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 4'hF, 32'h610 + 32'(4*i), 32'h6100 + 32'(i), 1'b1, 32'h40);
    checkOutput("hold_full", {31'b0, bus.hold_flag_o}, 32'h1);
    applyStimulus(1'b1, 4'hF, 32'h604, 32'h0BAD0BAD, 1'b1, 32'h604);
    checkOutput("ovf_set", {31'b0, bus.overflow_o}, 32'h1);
    sw(32'h608, 32'h0608_0608);
    checkOutput("hold_stays", {31'b0, bus.hold_flag_o}, 32'h1);
    idle(6);
    lw(32'h604);
    checkOutput("dropped_absent", bus.mem_rd_data_o, 32'h0604_0604);
    lw(32'h608);
    lw(32'h610);
    lw(32'h61C);
    idle(2);

    // pointer wrap over 10 stores interleaved with loads, then read back
    for (int i = 0; i < 10; i++) begin
      sw(32'h700 + 32'(4*i), 32'h7000 + 32'(i));
      lw(32'h700 + 32'(4*i));
    end
    idle(6);
    for (int i = 0; i < 10; i++) lw(32'h700 + 32'(4*i));
    idle(2);

    // address aliasing above the RAM size
    sw(32'h4008, 32'hCAFEF00D);
    idle(2);
    lw(32'h8);
    checkOutput("alias_word2", bus.mem_rd_data_o, 32'hCAFEF00D);
    idle(2);

    // reset with three stores buffered, a drain pending and a load in flight
    applyStimulus(1'b1, 4'hF, 32'h500, 32'h1111_0500, 1'b1, 32'h40);
    applyStimulus(1'b1, 4'hF, 32'h504, 32'h1111_0504, 1'b1, 32'h40);
    applyStimulus(1'b1, 4'hF, 32'h508, 32'h1111_0508, 1'b1, 32'h40);
    doReset();
    lw(32'h500);
    checkOutput("rst_prior_500", bus.mem_rd_data_o, 32'hA5A5_0500);
    lw(32'h504);
    lw(32'h508);
    checkOutput("rst_prior_508", bus.mem_rd_data_o, 32'hA5A5_0508);
    idle(3);

    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_wbuf.md
# dmem_wbuf

Data-memory responder for the store/load port driven by the execute stage. It accepts byte-lane stores (`mem_wr_req`/`sel`/`addr`/`data`) into a small posted-write buffer and drains them into a single-port synchronous word RAM whenever the port is idle. It answers loads with one-cycle latency. Load data merges RAM contents with any still-buffered stores, so program order is preserved. `hold_flag_o` goes to the pipeline control block to stall the core while the buffer is full.

## Interface
- `AW`, default 12: RAM word-address width; depth = 2^AW 32-bit words.
- `WB_DEPTH`, default 4: write-buffer entries; power of two, ≥2.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `mem_wr_req_i`  in  1: store request, one store per asserted cycle.
- `mem_wr_sel_i`  in  4: byte-lane enables; bit k selects data[8k+7:8k].
- `mem_wr_addr_i`  in  32: store byte address; word index = addr[AW+1:2]; other bits ignored.
- `mem_wr_data_i`  in  32: store data, already lane-aligned.
- `mem_rd_req_i`  in  1: load request.
- `mem_rd_addr_i`  in  32: load byte address; word index = addr[AW+1:2].
- `mem_rd_data_o`  out  32: full merged word for the last load; held until the next load completes.
- `mem_rd_valid_o`  out  1: one-cycle pulse, one cycle after `mem_rd_req_i`.
- `hold_flag_o`  out  1: buffer full; the control block must stall stores.
- `overflow_o`  out  1: sticky flag, set when a store is dropped.

## Operation
- Buffer is a circular FIFO (head/tail pointers plus count 0..WB_DEPTH). Each entry holds {word index, sel, data}.
- Enqueue: when `mem_wr_req_i`=1 and `mem_wr_sel_i`≠0, the store is written at the tail, unless it is dropped under the rule below. `sel`=0 is a no-op.
- Drain: when count>0 and `mem_rd_req_i`=0, the head entry is written to RAM with per-byte enables and popped. Loads own the RAM port; a load cycle never drains.
- Simultaneous enqueue and drain is allowed; count is unchanged.
- Full case: count==WB_DEPTH and a store arrives.
  - If a drain also happens that cycle, the store is accepted.
  - If a load is present (no drain), the store is dropped and `overflow_o` sets. It clears only on reset.
- Load at cycle N:
  - RAM read of the word index is issued.
  - A forward mask/data is computed per byte lane. Sources are applied oldest to newest: all valid buffer entries with a matching index, then the same-cycle store if its index matches. A same-cycle store counts as older than the load.
  - Mask and data are registered.
  - At N+1: `mem_rd_data_o` = forwarded bytes where the mask is set, RAM bytes elsewhere.
- Pointers wrap modulo WB_DEPTH. RAM addresses wrap modulo 2^AW.
- `hold_flag_o` = (count==WB_DEPTH), registered, i.e. derived from the count after the clock edge.

## Timing
- Reset values: `mem_rd_data_o`=0, `mem_rd_valid_o`=0, `hold_flag_o`=0, `overflow_o`=0; count, head and tail = 0. RAM contents are not reset.
- Reset mid-operation discards all buffered stores and any in-flight load; no valid pulse follows.
- Load latency is exactly 1 cycle, independent of buffer state. Back-to-back loads give a valid pulse every cycle.
- Store visibility:
  - To loads: from the same cycle, via forwarding.
  - Earliest RAM commit: cycle N+1, if that cycle has no load.
- Drain throughput: 1 entry per load-free cycle.
- `hold_flag_o` rises the cycle after the count reaches WB_DEPTH. It falls the cycle after the first drain.

## Test plan
- Reset: assert `rst_n`=0 mid-drain with 3 entries buffered → all outputs 0; after release, a load of those words returns the RAM's prior contents; no `overflow_o`.
- SW then LW: SW 0xDEADBEEF to 0x100 at N; LW 0x100 at N (same cycle) and at N+1 → both return 0xDEADBEEF with `mem_rd_valid_o` at N+1 and N+2.
- Byte merge: RAM[0x40]=0x11223344; SB sel=0010 data=0x0000AA00 to 0x41; SB sel=1000 data=0xBB000000 to 0x43; then LW 0x40 with both stores still buffered → 0xBB22AA44. After draining, LW 0x40 → same value.
- Newest wins: two SW to 0x200, 0x1 then 0x2, followed by continuous loads (no drain) → load returns 0x2.
- Full/overflow (WB_DEPTH=4): 4 SW during continuous loads → `hold_flag_o`=1 next cycle. 5th SW with a load in the same cycle → `overflow_o`=1, store absent. 5th SW in a load-free cycle instead → accepted, count stays 4.
- Wrap: 10 SW/drain cycles interleaved with loads → pointers wrap and all 10 words read back correctly. Address 0x4000+0x8 (AW=12) aliases to word 2.
